// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types, constants and helpers for the 4x4 keypad
//                scanner (scan/debounce state encoding, column reset
//                pattern, lowest-zero-bit index helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Index of the lowest bit that is 0. With no zero bit the result is 0;
  // callers only use it on vectors known to contain a zero.
  function automatic logic [1:0] row_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad-side and consumer-side signals of the scanner.
//                  row_in   - keypad rows, active low (into scanner)
//                  col_out  - one-hot-low column drive (from scanner)
//                  keyEvent - high while a debounced key is held
//                  keyValue - code of the last accepted key (row*4 + col)
//                master = scanner, slave = keypad/consumer environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       keyEvent;
  logic [3:0] keyValue;

  modport master (
    input  row_in,
    output col_out,
    output keyEvent,
    output keyValue
  );

  modport slave (
    output row_in,
    input  col_out,
    input  keyEvent,
    input  keyValue
  );
endinterface : keypad_scanner_if
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser for asynchronous inputs.
//  Ports       : clk   - clock
//                rst   - asynchronous active-low reset (loads RESET_VAL)
//                d     - asynchronous input
//                q     - synchronised output
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a 4x4 active-low matrix keypad, debounces presses and
//                releases, and emits a keyEvent level plus keyValue code.
//  Ports       : clk - system clock, rising edge
//                rst - asynchronous active-low reset
//                kif - keypad_scanner_if.master (row_in, col_out,
//                      keyEvent, keyValue)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scanner_if.master   kif
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(DEBOUNCE_CNT);
  // The current sample is the one that completes the count when dcnt already
  // holds DEBOUNCE_CNT-1 agreeing samples.
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CNT - 1);

  logic [3:0]        row_s;

  state_t            state_q,     state_d;
  logic [DIV_W-1:0]  div_q,       div_d;
  logic [3:0]        col_q,       col_d;
  logic [1:0]        row_idx_q,   row_idx_d;
  logic [1:0]        col_idx_q,   col_idx_d;
  logic [DCNT_W-1:0] dcnt_q,      dcnt_d;
  logic              key_event_q, key_event_d;
  logic [3:0]        key_value_q, key_value_d;

  logic              sample;
  logic              key_low;
  logic              dcnt_done;
  logic [3:0]        col_next;

  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (kif.row_in),
    .q   (row_s)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    dcnt_d      = dcnt_q;
    key_event_d = key_event_q;
    key_value_d = key_value_q;

    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    sample    = (div_q == DIV_LAST);
    key_low   = ~row_s[row_idx_q];
    dcnt_done = (dcnt_q >= DCNT_LAST);
    col_next  = {col_q[2:0], col_q[3]};

    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (row_s == 4'hF) begin
            col_d = col_next;
          end else begin
            row_idx_d = row_to_idx(row_s);
            col_idx_d = row_to_idx(col_q);
            dcnt_d    = DCNT_ONE;
            // A single required sample means the detecting sample accepts.
            if (DEBOUNCE_CNT == 1) begin
              key_value_d = {row_to_idx(row_s), row_to_idx(col_q)};
              key_event_d = 1'b1;
              state_d     = HELD;
            end else begin
              state_d     = DEB_PRESS;
            end
          end
        end
      end

      DEB_PRESS: begin
        if (sample) begin
          if (key_low) begin
            if (dcnt_done) begin
              dcnt_d      = DCNT_MAX;
              key_value_d = {row_idx_q, col_idx_q};
              key_event_d = 1'b1;
              state_d     = HELD;
            end else begin
              dcnt_d      = dcnt_q + 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_next;
          end
        end
      end

      HELD: begin
        if (sample && !key_low) begin
          dcnt_d = DCNT_ONE;
          if (DEBOUNCE_CNT == 1) begin
            key_event_d = 1'b0;
            state_d     = SCAN;
            col_d       = col_next;
          end else begin
            state_d     = DEB_RELEASE;
          end
        end
      end

      DEB_RELEASE: begin
        if (sample) begin
          if (!key_low) begin
            if (dcnt_done) begin
              dcnt_d      = DCNT_MAX;
              key_event_d = 1'b0;
              state_d     = SCAN;
              col_d       = col_next;
            end else begin
              dcnt_d      = dcnt_q + 1'b1;
            end
          end else begin
            state_d = HELD;
          end
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      div_q       <= '0;
      col_q       <= COL_RESET;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      dcnt_q      <= '0;
      key_event_q <= 1'b0;
      key_value_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      dcnt_q      <= dcnt_d;
      key_event_q <= key_event_d;
      key_value_q <= key_value_d;
    end
  end

  assign kif.col_out  = col_q;
  assign kif.keyEvent = key_event_q;
  assign kif.keyValue = key_value_q;

endmodule : keypad_scanner
`default_nettype wire
